// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// =============================================================================
// uart_rx_ctrl : configures, sequences and buffers the UART receive core.
// Optional feature macro: UART_RX_CTRL_ERRCNT_EN (parity-error counter).
// Revision: 1.0
// =============================================================================
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [7:0]                    cfg_wdata,
    output logic                          cfg_err,
    output logic                          rx_rst,
    output logic [3:0]                    rx_amount_bits,
    output logic                          rx_parity,
    output logic                          rx_even,
    output logic                          rx_stop,
    output logic                          rx_handshake,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    input  logic                          rx_error,
    output logic                          rts,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic [7:0]                    err_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] C_ST_RESET    = 2'd0;
    localparam logic [1:0] C_ST_RUN      = 2'd1;
    localparam logic [1:0] C_ST_RECONFIG = 2'd2;
    localparam logic [1:0] C_ST_RECOVER  = 2'd3;

    // 8 data bits, no parity, one stop bit, no handshake
    localparam logic [7:0]       C_CFG_RESET = 8'h82;
    localparam logic [CNT_W-1:0] C_FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] C_RTS_LIMIT = CNT_W'(FIFO_DEPTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_hold;
    logic             w_hold_nxt;
    logic             r_rx_rst;
    logic [7:0]       r_cfg;
    logic             r_cfg_err;
    logic             r_ready_q;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_live;
    logic w_cfg_ok;
    logic w_cfg_load;
    logic w_cfg_bad;
    logic w_err_evt;
    logic w_clr;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_wr;
    logic w_rts;

    assign w_live     = (r_state != C_ST_RESET);
    assign w_cfg_ok   = (cfg_wdata[7:4] >= 4'd5) && (cfg_wdata[7:4] <= 4'd8);
    assign w_cfg_load = w_live && cfg_we && w_cfg_ok;
    assign w_cfg_bad  = w_live && cfg_we && !w_cfg_ok;
    assign w_err_evt  = (r_state == C_ST_RUN) && rx_error;
    assign w_clr      = w_live && err_clr;

    assign w_push = (r_state == C_ST_RUN) && rx_ready && !r_ready_q;
    assign w_pop  = rd_en && (r_count != '0);
    assign w_full = (r_count == C_FULL_CNT);
    assign w_wr   = w_push && (!w_full || w_pop);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= C_ST_RESET;
            r_hold   <= 1'b0;
            r_rx_rst <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_rx_rst <= (w_state_nxt != C_ST_RUN);
        end
    end

    // Next-state logic; r_hold marks the second cycle of a two-cycle state
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = 1'b0;
        case (r_state)
            C_ST_RESET: begin
                if (r_hold) w_state_nxt = C_ST_RUN;
                else        w_hold_nxt  = 1'b1;
            end
            C_ST_RUN: begin
                if (w_err_evt) w_state_nxt = C_ST_RECOVER;
            end
            C_ST_RECONFIG: begin
                if (r_hold) w_state_nxt = C_ST_RUN;
                else        w_hold_nxt  = 1'b1;
            end
            C_ST_RECOVER: begin
                w_state_nxt = C_ST_RUN;
            end
            default: begin
                w_state_nxt = C_ST_RESET;
            end
        endcase
        if (w_cfg_load) begin
            w_state_nxt = C_ST_RECONFIG;
            w_hold_nxt  = 1'b0;
        end
    end

    // Output decode from registered state
    always_comb begin
        w_rts = 1'b1;
        if ((r_state == C_ST_RESET) || (r_state == C_ST_RECONFIG)) begin
            w_rts = 1'b0;
        end else if (r_cfg[0]) begin
            w_rts = (r_count < C_RTS_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg     <= C_CFG_RESET;
            r_cfg_err <= 1'b0;
            r_ready_q <= 1'b0;
        end else begin
            if (w_cfg_load) r_cfg <= cfg_wdata;
            r_cfg_err <= w_cfg_bad;
            r_ready_q <= rx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_clr) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef UART_RX_CTRL_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_clr) begin
            r_err_count <= 8'd0;
        end else if (w_err_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

    assign cfg_err        = r_cfg_err;
    assign rx_rst         = r_rx_rst;
    assign rx_amount_bits = r_cfg[7:4];
    assign rx_parity      = r_cfg[3];
    assign rx_even        = r_cfg[2];
    assign rx_stop        = r_cfg[1];
    assign rx_handshake   = r_cfg[0];
    assign rts            = w_rts;
    assign rd_valid       = (r_count != '0);
    assign rd_data        = (r_count != '0) ? r_mem[r_rd_ptr] : 8'd0;
    assign fifo_count     = r_count;
    assign overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// =============================================================================
// tb_uart_rx_ctrl : directed and random checks of uart_rx_ctrl against a
// queue/countdown reference model.  Revision: 1.0
// =============================================================================
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
`ifdef UART_RX_CTRL_ERRCNT_EN
    localparam bit EC_ON = 1'b1;
`else
    localparam bit EC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_wdata;
    logic       cfg_err;
    logic       rx_rst;
    logic [3:0] rx_amount_bits;
    logic       rx_parity;
    logic       rx_even;
    logic       rx_stop;
    logic       rx_handshake;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       rts;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       err_clr;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .rx_rst(rx_rst), .rx_amount_bits(rx_amount_bits),
        .rx_parity(rx_parity), .rx_even(rx_even), .rx_stop(rx_stop),
        .rx_handshake(rx_handshake), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_error(rx_error), .rts(rts), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count), .overflow(overflow),
        .err_clr(err_clr), .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue plus a countdown of core-reset cycles
    logic [7:0] m_q[$];
    int         m_busy = 2;
    bit         m_block = 1'b1;
    bit         m_in_reset = 1'b1;
    logic [7:0] m_cfg = 8'h82;
    bit         m_ovf = 1'b0;
    int         m_ec = 0;
    bit         m_cfgerr = 1'b0;
    bit         m_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_q.delete();
            m_busy     = 2;
            m_block    = 1'b1;
            m_in_reset = 1'b1;
            m_cfg      = 8'h82;
            m_ovf      = 1'b0;
            m_ec       = 0;
            m_cfgerr   = 1'b0;
            m_prev     = 1'b0;
        end else begin
            bit run  = (m_busy == 0);
            bit live = !m_in_reset;
            bit ok   = (cfg_wdata[7:4] >= 4'd5) && (cfg_wdata[7:4] <= 4'd8);
            bit push = run && rx_ready && !m_prev;
            bit pop  = rd_en && (m_q.size() > 0);
            bit err  = run && rx_error;
            int pre  = m_q.size();
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (pre < DEPTH || pop) m_q.push_back(rx_data);
                else                    m_ovf = 1'b1;
            end
            if (err && m_ec < 255) m_ec++;
            if (live && err_clr) begin
                m_ovf = 1'b0;
                m_ec  = 0;
            end
            m_cfgerr = live && cfg_we && !ok;
            if (live && cfg_we && ok) begin
                m_cfg   = cfg_wdata;
                m_busy  = 2;
                m_block = 1'b1;
            end else if (err) begin
                m_busy  = 1;
                m_block = 1'b0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_in_reset = 1'b0;
                    m_block    = 1'b0;
                end
            end
            m_prev = rx_ready;
        end
    endtask

    task automatic check_all();
        int  sz = m_q.size();
        bit  exp_rts = m_block ? 1'b0 : (m_cfg[0] ? (sz < DEPTH - 1) : 1'b1);
        check("rx_rst",     32'(rx_rst),         32'(m_busy != 0));
        check("rts",        32'(rts),            32'(exp_rts));
        check("cfg_err",    32'(cfg_err),        32'(m_cfgerr));
        check("cfg",        32'({rx_amount_bits, rx_parity, rx_even, rx_stop, rx_handshake}), 32'(m_cfg));
        check("rd_valid",   32'(rd_valid),       32'(sz > 0));
        check("rd_data",    32'(rd_data),        (sz > 0) ? 32'(m_q[0]) : 32'd0);
        check("fifo_count", 32'(fifo_count),     32'(sz));
        check("overflow",   32'(overflow),       32'(m_ovf));
        check("err_count",  32'(err_count),      EC_ON ? 32'(m_ec) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] b);
        check(tag, 32'(rd_data), 32'(b));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_wdata = 8'h00; rx_data = 8'h00;
        rx_ready = 1'b0; rx_error = 1'b0; rd_en = 1'b0; err_clr = 1'b0;

        // Reset for 3 cycles, then rx_rst high for exactly 2 cycles
        repeat (3) tick();
        check("rst_amount", 32'(rx_amount_bits), 32'd8);
        check("rst_stop",   32'(rx_stop),        32'd1);
        check("rst_rts",    32'(rts),            32'd0);
        rst_n = 1'b1;
        check("rel_rx_rst0", 32'(rx_rst), 32'd1);
        tick();
        check("rel_rx_rst1", 32'(rx_rst), 32'd1);
        tick();
        check("rel_rx_rst2", 32'(rx_rst), 32'd0);
        check("rel_rts",     32'(rts),    32'd1);

        // Single byte push and pop
        rx_data = 8'hA5; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("single_valid", 32'(rd_valid), 32'd1);
        check("single_data",  32'(rd_data),  32'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("single_empty", 32'(rd_valid),   32'd0);
        check("single_count", 32'(fifo_count), 32'd0);

        // Invalid then valid configuration
        cfg_wdata = 8'h96; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("cfg_bad_err", 32'(cfg_err),        32'd1);
        check("cfg_bad_amt", 32'(rx_amount_bits), 32'd8);
        tick();
        check("cfg_err_pulse", 32'(cfg_err), 32'd0);
        cfg_wdata = 8'h7A; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("cfg_amt",    32'(rx_amount_bits), 32'd7);
        check("cfg_par",    32'({rx_parity, rx_even, rx_stop, rx_handshake}), 32'b1010);
        check("cfg_rst1",   32'(rx_rst), 32'd1);
        tick();
        check("cfg_rst2",   32'(rx_rst), 32'd1);
        tick();
        check("cfg_rst3",   32'(rx_rst), 32'd0);

        // Fill and overflow with handshake enabled
        cfg_wdata = 8'h83; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        repeat (2) tick();
        push_byte(8'h01);
        push_byte(8'h02);
        check("fill_rts2", 32'(rts), 32'd1);
        push_byte(8'h03);
        check("fill_rts3", 32'(rts), 32'd0);
        push_byte(8'h04);
        check("fill_ovf4", 32'(overflow), 32'd0);
        push_byte(8'h05);
        check("fill_ovf5", 32'(overflow), 32'd1);
        pop_expect("pop01", 8'h01);
        pop_expect("pop02", 8'h02);
        pop_expect("pop03", 8'h03);
        pop_expect("pop04", 8'h04);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop
        push_byte(8'hB0);
        push_byte(8'hB1);
        push_byte(8'hB2);
        push_byte(8'hB3);
        rx_data = 8'hC4; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf",   32'(overflow),   32'd0);
        pop_expect("pp_b1", 8'hB1);
        pop_expect("pp_b2", 8'hB2);
        pop_expect("pp_b3", 8'hB3);
        pop_expect("pp_c4", 8'hC4);

        // Parity error recovery
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        check("rec_rst1", 32'(rx_rst),    32'd1);
        check("rec_ec",   32'(err_count), EC_ON ? 32'd1 : 32'd0);
        tick();
        check("rec_rst2", 32'(rx_rst), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("rec_clr", 32'(err_count), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            cfg_we    = ($urandom_range(0, 24) == 0);
            cfg_wdata = {4'($urandom_range(4, 9)), 4'($urandom)};
            rx_ready  = 1'($urandom_range(0, 1));
            rx_data   = 8'($urandom);
            rx_error  = ($urandom_range(0, 19) == 0);
            rd_en     = ($urandom_range(0, 2) == 0);
            err_clr   = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst_n = 1'b1; cfg_we = 1'b0; rx_ready = 1'b0; rx_error = 1'b0;
        rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that configures, sequences and buffers the UART receive core. It owns the frame-format register and drives it onto the core. It resets the core after power-up, after every reconfiguration and after every parity failure, because the core's failed state is sticky. It captures each completed byte into a small first-word-fall-through FIFO for the host and drives the RTS flow-control line.

## Interface
- FIFO_DEPTH, 4: receive FIFO entries (power of two, ≥2)
- clk  in  1  system/bit clock shared with the receive core
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  config write strobe
- cfg_wdata  in  8  {amount_bits[7:4], parity[3], even[2], stop[1], handshake[0]}
- cfg_err  out  1  one-cycle pulse: write rejected
- rx_rst  out  1  active-high synchronous reset to core
- rx_amount_bits  out  4  to core
- rx_parity, rx_even, rx_stop, rx_handshake  out  1 each  to core
- rx_data  in  8  core data
- rx_ready  in  1  core byte-complete
- rx_error  in  1  core parity failure (sticky until rx_rst)
- rts  out  1  high = peer may transmit
- rd_en  in  1  host pop
- rd_data  out  8  FIFO head (valid when rd_valid)
- rd_valid  out  1  FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: byte dropped
- err_clr  in  1  clears overflow and err_count
- err_count  out  8  saturating parity-error count

## Operation
- FSM states: RESET, RUN, RECONFIG, RECOVER. rx_rst is registered; it is 1 in every state except RUN.
- RESET: entered on rst_n=0. Held 2 cycles after rst_n rises, then RUN.
- RUN, cfg_we with amount_bits in 5..8: load config register, go to RECONFIG. Any in-flight frame is discarded.
- RUN, cfg_we with amount_bits outside 5..8: config unchanged, cfg_err pulses for 1 cycle, state unchanged.
- RECONFIG: lasts 2 cycles, then RUN.
- RUN, rx_error=1 with no cfg_we: go to RECOVER and increment err_count (saturates at 255).
- RECOVER: lasts 1 cycle, then RUN. rx_error is ignored in RECOVER, RECONFIG and RESET.
- cfg_we and rx_error in the same cycle: the valid config takes effect (RECONFIG) and err_count still increments. With an invalid config, RECOVER is taken and cfg_err pulses.
- Push condition: in RUN, rx_ready rising edge (rx_ready=1 and registered previous rx_ready=0) pushes rx_data.
- Full FIFO without a same-cycle pop: byte is dropped and overflow is set.
- Pop: rd_en with rd_valid=1 pops the head. rd_en on an empty FIFO is ignored.
- Push and pop in the same cycle: legal at any occupancy, including full. fifo_count is unchanged and no overflow occurs.
- Pointers wrap modulo FIFO_DEPTH.
- rts with handshake=1: rts = (fifo_count < FIFO_DEPTH-1). One slot stays reserved for an in-flight byte.
- rts with handshake=0: rts=1.
- rts is 0 in RESET and RECONFIG.
- err_clr: clears overflow and err_count. It wins over a same-cycle set or increment.
- cfg_we and err_clr are sampled in every state except RESET. A cfg_we during RECONFIG or RECOVER gets the same validity check and restarts RECONFIG at 2 cycles.

## Timing
- Reset values:
  - rx_rst=1, cfg_err=0, rts=0
  - rx_amount_bits=8, rx_parity=0, rx_even=0, rx_stop=1, rx_handshake=0 (8N1)
  - rd_data=0, rd_valid=0, fifo_count=0, overflow=0, err_count=0
- rst_n=0 mid-operation empties the FIFO and restores all reset values on the next edge.
- Push latency: rx_ready first seen high in cycle t gives rd_valid=1, updated rd_data and fifo_count in cycle t+1.
- Pop: rd_en in cycle t updates rd_data and fifo_count in t+1.
- Error recovery: rx_error seen in cycle t gives rx_rst=1 in t+1 only, and RUN in t+2.
- Reconfiguration: cfg_we in cycle t updates the core config outputs in t+1 and holds rx_rst=1 in t+1 and t+2.
- cfg_err: asserted in t+1 for 1 cycle.
- rts follows fifo_count combinationally from registered state.

## Configuration
- UART_RX_CTRL_ERRCNT_EN defined: err_count is implemented as above.
- UART_RX_CTRL_ERRCNT_EN undefined: err_count is tied to 8'd0 and no counter register exists. RECOVER sequencing is unchanged.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release. Require all reset values, rx_rst=1 for exactly 2 cycles after release, then rts=1.
- Single byte: rx_data=8'hA5 with a 1-cycle rx_ready. Require rd_valid=1 and rd_data=8'hA5 next cycle. rd_en=1 then gives rd_valid=0 and fifo_count=0.
- Fill and overflow: handshake=1, FIFO_DEPTH=4, push 8'h01 to 8'h05 with no pops. Require rts=0 once fifo_count=3 and overflow=1 after the 5th push. Pops then return 01, 02, 03, 04.
- Error recovery: hold rx_error=1. Require rx_rst high for exactly 1 cycle and err_count=1. err_clr=1 then gives err_count=0.
- Config: cfg_wdata=8'h96 (9 bits) gives cfg_err pulse with config unchanged. cfg_wdata=8'h7A gives rx_amount_bits=7, parity=1, even=0, stop=1, handshake=0, and rx_rst high for 2 cycles.
- Full with simultaneous push and pop: FIFO full, rx_ready rising edge with rd_en=1. Require fifo_count=4, overflow=0, and FIFO order preserved.
